// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
//   - funct3 load encodings (F3_LB .. F3_LHU)
//   - wb_state_t: miss-handling FSM states
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        StRun,
        StMissWait,
        StReplay,
        StDrain
    } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB bus plus the write-back outputs.
//   master: MEM stage / cache side (drives mem_*, flush, refill_complete)
//   slave : wb_stage (drives stall_req, wb_*, misalign_err, perf_stall_cycles)
interface wb_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            flush;
    logic            mem_valid;
    logic            mem_reg_write;
    logic            mem_mem_to_reg;
    logic [2:0]      mem_funct3;
    logic [RA_W-1:0] mem_rd;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_load_data;
    logic            mem_load_miss;
    logic            refill_complete;

    logic            stall_req;
    logic            wb_we;
    logic [RA_W-1:0] wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            misalign_err;
    logic [31:0]     perf_stall_cycles;

    modport master (
        output flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_funct3, mem_rd,
               mem_alu_result, mem_load_data, mem_load_miss, refill_complete,
        input  stall_req, wb_we, wb_rd, wb_data, misalign_err, perf_stall_cycles
    );

    modport slave (
        input  flush, mem_valid, mem_reg_write, mem_mem_to_reg, mem_funct3, mem_rd,
               mem_alu_result, mem_load_data, mem_load_miss, refill_complete,
        output stall_req, wb_we, wb_rd, wb_data, misalign_err, perf_stall_cycles
    );

endinterface

// File: rtl/load_align.sv
// load_align: combinational load-data aligner.
//   funct3_i     : load size/sign
//   offset_i     : byte offset within the word (address[1:0])
//   raw_i        : raw word from the data cache
//   data_o       : selected and sign/zero-extended result
//   misaligned_o : halfword on odd offset, or word on nonzero offset
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      offset_i,
    input  logic [XLEN-1:0] raw_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[{offset_i, 3'b000} +: 8];
    assign half_sel = raw_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o       = raw_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o       = {{(XLEN-16){half_sel[15]}}, half_sel};
                misaligned_o = offset_i[0];
            end
            F3_LHU: begin
                data_o       = {{(XLEN-16){1'b0}}, half_sel};
                misaligned_o = offset_i[0];
            end
            // LW and unused encodings take the whole word
            default: begin
                data_o       = raw_i;
                misaligned_o = |offset_i;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: pipeline write-back stage.
// Registers the MEM result, aligns load data, drives the register-file write port,
// and holds the pipeline across a data-cache load miss (MISS_WAIT -> REPLAY commit,
// or DRAIN when the load was flushed).
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : wb_stage_if.slave (MEM inputs in; stall_req, wb_*, misalign_err,
//         perf_stall_cycles out)
// Configuration: define WB_PERF_CNT_EN to build the saturating stall-cycle counter;
// otherwise perf_stall_cycles is tied to zero.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus
);

    wb_state_t       state_q, state_d;
    logic            stall_q, stall_d;
    logic            we_q, we_d;
    logic            mis_q, mis_d;
    logic [RA_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d;
    // fields of the missed load, replayed once the refill lands
    logic [2:0]      lf3_q, lf3_d;
    logic [1:0]      loff_q, loff_d;
    logic            lrw_q, lrw_d;

    logic [2:0]      al_f3;
    logic [1:0]      al_off;
    logic [XLEN-1:0] al_data;
    logic            al_mis;
    logic            take;
    logic            load_mis;

    // one aligner shared by RUN (live fields) and REPLAY (latched fields)
    assign al_f3  = (state_q == StReplay) ? lf3_q  : bus.mem_funct3;
    assign al_off = (state_q == StReplay) ? loff_q : bus.mem_alu_result[1:0];

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .funct3_i     (al_f3),
        .offset_i     (al_off),
        .raw_i        (bus.mem_load_data),
        .data_o       (al_data),
        .misaligned_o (al_mis)
    );

    assign take     = bus.mem_valid && !bus.flush;
    assign load_mis = bus.mem_mem_to_reg && al_mis;

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        we_d    = 1'b0;
        mis_d   = 1'b0;
        rd_d    = rd_q;
        data_d  = data_q;
        lf3_d   = lf3_q;
        loff_d  = loff_q;
        lrw_d   = lrw_q;

        unique case (state_q)
            StRun: begin
                if (take) begin
                    rd_d   = bus.mem_rd;
                    data_d = bus.mem_mem_to_reg ? al_data : bus.mem_alu_result;
                    // a misaligned load faults instead of missing
                    if (bus.mem_mem_to_reg && bus.mem_load_miss && !al_mis) begin
                        state_d = StMissWait;
                        stall_d = 1'b1;
                        lf3_d   = bus.mem_funct3;
                        loff_d  = bus.mem_alu_result[1:0];
                        lrw_d   = bus.mem_reg_write;
                    end else begin
                        we_d  = bus.mem_reg_write && (bus.mem_rd != '0) && !load_mis;
                        mis_d = load_mis;
                    end
                end
            end
            StMissWait: begin
                if (bus.flush) begin
                    if (bus.refill_complete) begin
                        state_d = StRun;
                        stall_d = 1'b0;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (bus.refill_complete) begin
                    state_d = StReplay;
                end
            end
            StReplay: begin
                // commits regardless of flush: the replayed load is architectural
                state_d = StRun;
                stall_d = 1'b0;
                data_d  = al_data;
                we_d    = lrw_q && (rd_q != '0);
            end
            StDrain: begin
                if (bus.refill_complete) begin
                    state_d = StRun;
                    stall_d = 1'b0;
                end
            end
            default: begin
                state_d = StRun;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            stall_q <= 1'b0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            lf3_q   <= '0;
            loff_q  <= '0;
            lrw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            we_q    <= we_d;
            mis_q   <= mis_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            lf3_q   <= lf3_d;
            loff_q  <= loff_d;
            lrw_q   <= lrw_d;
        end
    end

    assign bus.stall_req    = stall_q;
    assign bus.wb_we        = we_q;
    assign bus.wb_rd        = rd_q;
    assign bus.wb_data      = data_q;
    assign bus.misalign_err = mis_q;

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (stall_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.perf_stall_cycles = perf_q;
`else
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a behavioural reference model and a
// per-cycle compare process, plus literal expectations for the key scenarios.
module tb_wb_stage;
    import wb_pkg::*;

`ifdef WB_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_stall;
    int   n_we;
    bit   chk_on = 1'b0;

    wb_stage_if #(.XLEN(32), .RA_W(5)) bus ();

    wb_stage #(
        .XLEN (32),
        .RA_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference alignment: returns {misaligned, value}, built from shifts and arithmetic.
    function automatic logic [32:0] ref_align(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] raw);
        logic [31:0] v;
        logic        mis;
        mis = 1'b0;
        case (f3)
            3'b000, 3'b100: begin
                v = (raw >> (8 * off)) & 32'h0000_00FF;
                if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                mis = off[0];
                v = (raw >> (16 * off[1])) & 32'h0000_FFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: begin
                mis = (off != 2'd0);
                v = raw;
            end
        endcase
        return {mis, v};
    endfunction

    // ---------------- reference model ----------------
    logic        e_we, e_mis, e_stall;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_perf;
    logic        m_pending, m_kill, m_replay, m_rw;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic [32:0] run_al, rep_al;

    assign run_al = ref_align(bus.mem_funct3, bus.mem_alu_result[1:0], bus.mem_load_data);
    assign rep_al = ref_align(m_f3, m_off, bus.mem_load_data);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_we <= 1'b0; e_mis <= 1'b0; e_stall <= 1'b0; e_rd <= '0; e_data <= '0;
            e_perf <= '0; m_pending <= 1'b0; m_kill <= 1'b0; m_replay <= 1'b0;
            m_rw <= 1'b0; m_rd <= '0; m_f3 <= '0; m_off <= '0;
        end else begin
            e_we  <= 1'b0;
            e_mis <= 1'b0;
            if (PERF_EN && e_stall && e_perf != 32'hFFFF_FFFF) e_perf <= e_perf + 32'd1;
            if (m_replay) begin
                m_replay <= 1'b0;
                e_stall  <= 1'b0;
                e_we     <= m_rw && (m_rd != 5'd0);
                e_rd     <= m_rd;
                e_data   <= rep_al[31:0];
            end else if (m_pending) begin
                if (m_kill || bus.flush) begin
                    if (bus.refill_complete) begin
                        m_pending <= 1'b0; m_kill <= 1'b0; e_stall <= 1'b0;
                    end else begin
                        m_kill <= 1'b1;
                    end
                end else if (bus.refill_complete) begin
                    m_pending <= 1'b0;
                    m_replay  <= 1'b1;
                end
            end else if (bus.mem_valid && !bus.flush) begin
                if (bus.mem_mem_to_reg && bus.mem_load_miss && !run_al[32]) begin
                    m_pending <= 1'b1; e_stall <= 1'b1;
                    m_rd <= bus.mem_rd; m_f3 <= bus.mem_funct3;
                    m_off <= bus.mem_alu_result[1:0]; m_rw <= bus.mem_reg_write;
                end else begin
                    e_rd   <= bus.mem_rd;
                    e_data <= bus.mem_mem_to_reg ? run_al[31:0] : bus.mem_alu_result;
                    e_we   <= bus.mem_reg_write && (bus.mem_rd != 5'd0) &&
                              !(bus.mem_mem_to_reg && run_al[32]);
                    e_mis  <= bus.mem_mem_to_reg && run_al[32];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst && chk_on) begin
            check("we", 32'(bus.wb_we), 32'(e_we));
            check("misalign_err", 32'(bus.misalign_err), 32'(e_mis));
            check("stall_req", 32'(bus.stall_req), 32'(e_stall));
            check("perf_stall_cycles", bus.perf_stall_cycles, e_perf);
            if (e_we) begin
                check("wb_rd", 32'(bus.wb_rd), 32'(e_rd));
                check("wb_data", bus.wb_data, e_data);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.flush = 1'b0; bus.mem_valid = 1'b0; bus.mem_reg_write = 1'b0;
        bus.mem_mem_to_reg = 1'b0; bus.mem_funct3 = 3'b000; bus.mem_rd = '0;
        bus.mem_alu_result = '0; bus.mem_load_data = '0; bus.mem_load_miss = 1'b0;
        bus.refill_complete = 1'b0;
    endtask

    task automatic set_in(input logic rw, input logic m2r, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] ld, input logic miss);
        bus.mem_valid = 1'b1; bus.mem_reg_write = rw; bus.mem_mem_to_reg = m2r;
        bus.mem_funct3 = f3; bus.mem_rd = rd; bus.mem_alu_result = alu;
        bus.mem_load_data = ld; bus.mem_load_miss = miss;
    endtask

    task automatic cyc();
        @(negedge clk);
        if (bus.stall_req) n_stall++;
        if (bus.wb_we) n_we++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"}, 32'(bus.wb_we), 32'd0);
        check({tag, "_rd"}, 32'(bus.wb_rd), 32'd0);
        check({tag, "_data"}, bus.wb_data, 32'd0);
        check({tag, "_mis"}, 32'(bus.misalign_err), 32'd0);
        check({tag, "_stall"}, 32'(bus.stall_req), 32'd0);
        check({tag, "_perf"}, bus.perf_stall_cycles, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        chk_on = 1'b1;

        // LB sign-extends the top byte
        set_in(1'b1, 1'b1, F3_LB, 5'd3, 32'h1003, 32'h80FF_1234, 1'b0);
        cyc(); idle();
        check("lb_data", bus.wb_data, 32'hFFFF_FF80);
        check("lb_we", 32'(bus.wb_we), 32'd1);

        // LHU upper half
        set_in(1'b1, 1'b1, F3_LHU, 5'd4, 32'h1002, 32'hBEEF_0000, 1'b0);
        cyc(); idle();
        check("lhu_data", bus.wb_data, 32'h0000_BEEF);
        check("lhu_we", 32'(bus.wb_we), 32'd1);

        // LH odd address: one-cycle fault pulse, no write
        set_in(1'b1, 1'b1, F3_LH, 5'd6, 32'h1001, 32'h1234_5678, 1'b0);
        cyc(); idle();
        check("lh_mis", 32'(bus.misalign_err), 32'd1);
        check("lh_we", 32'(bus.wb_we), 32'd0);
        cyc();
        check("lh_mis_pulse", 32'(bus.misalign_err), 32'd0);

        // ALU results to x0 and x5, then a store
        set_in(1'b1, 1'b0, 3'b000, 5'd0, 32'h1234, 32'h0, 1'b0);
        cyc();
        check("x0_we", 32'(bus.wb_we), 32'd0);
        set_in(1'b1, 1'b0, 3'b000, 5'd5, 32'h1234, 32'h0, 1'b0);
        cyc();
        check("x5_we", 32'(bus.wb_we), 32'd1);
        check("x5_data", bus.wb_data, 32'h0000_1234);
        set_in(1'b0, 1'b0, F3_LW, 5'd9, 32'h0040, 32'h0, 1'b0);
        cyc(); idle();
        check("store_we", 32'(bus.wb_we), 32'd0);

        // LW miss, refill, replay commit
        n_stall = 0; n_we = 0;
        set_in(1'b1, 1'b1, F3_LW, 5'd7, 32'h2000, 32'h0, 1'b1);
        cyc(); idle();
        repeat (5) cyc();
        bus.refill_complete = 1'b1;
        cyc();
        bus.refill_complete = 1'b0;
        bus.mem_load_data = 32'hDEAD_BEEF;
        cyc(); idle();
        check("replay_we", 32'(bus.wb_we), 32'd1);
        check("replay_data", bus.wb_data, 32'hDEAD_BEEF);
        check("replay_rd", 32'(bus.wb_rd), 32'd7);
        repeat (2) cyc();
        check("miss_stall_cycles", 32'(n_stall), 32'd7);
        check("miss_commits", 32'(n_we), 32'd1);
        check("perf_after_miss", bus.perf_stall_cycles, PERF_EN ? 32'd7 : 32'd0);

        // flush while waiting, refill later: drain with no commit
        n_we = 0;
        set_in(1'b1, 1'b1, F3_LW, 5'd8, 32'h2004, 32'h0, 1'b1);
        cyc(); idle();
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        repeat (2) cyc();
        check("drain_stall", 32'(bus.stall_req), 32'd1);
        bus.refill_complete = 1'b1;
        cyc();
        bus.refill_complete = 1'b0;
        check("drain_release", 32'(bus.stall_req), 32'd0);
        repeat (2) cyc();
        check("drain_commits", 32'(n_we), 32'd0);

        // refill and flush together in MISS_WAIT
        n_we = 0;
        set_in(1'b1, 1'b1, F3_LW, 5'd9, 32'h2008, 32'h0, 1'b1);
        cyc(); idle();
        cyc();
        bus.flush = 1'b1; bus.refill_complete = 1'b1;
        cyc(); idle();
        check("flush_refill_stall", 32'(bus.stall_req), 32'd0);
        cyc();
        check("flush_refill_commits", 32'(n_we), 32'd0);

        // flush during REPLAY still commits; LBU at offset 1
        set_in(1'b1, 1'b1, F3_LBU, 5'd10, 32'h3001, 32'h0, 1'b1);
        cyc(); idle();
        cyc();
        bus.refill_complete = 1'b1;
        cyc();
        bus.refill_complete = 1'b0;
        bus.flush = 1'b1;
        bus.mem_load_data = 32'h0000_AB00;
        cyc(); idle();
        check("replay_flush_we", 32'(bus.wb_we), 32'd1);
        check("replay_flush_data", bus.wb_data, 32'h0000_00AB);

        // asynchronous reset while in MISS_WAIT
        set_in(1'b1, 1'b1, F3_LW, 5'd11, 32'h4000, 32'h0, 1'b1);
        cyc(); idle();
        repeat (2) cyc();
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        bus.refill_complete = 1'b1;
        bus.mem_load_data = 32'hFFFF_FFFF;
        n_we = 0;
        cyc();
        bus.refill_complete = 1'b0;
        repeat (3) cyc();
        check("post_rst_commits", 32'(n_we), 32'd0);
        check("post_rst_stall", 32'(bus.stall_req), 32'd0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage pipeline, directly downstream of the MEM stage. It registers the MEM result, aligns and sign/zero-extends load data by size and byte offset, and drives the register-file write port and the forwarding bus. It holds the pipeline on a data-cache load miss until refill completes, then replays the load read and commits it.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register-address width.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `flush` in 1: squash the in-flight MEM instruction.
- `mem_valid` in 1: MEM slot holds a real instruction.
- `mem_reg_write` in 1: instruction writes `rd`.
- `mem_mem_to_reg` in 1: result comes from load data, not the ALU.
- `mem_funct3` in 3: load size and sign. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `mem_rd` in RA_W: destination register.
- `mem_alu_result` in XLEN: ALU result, also the load address.
- `mem_load_data` in XLEN: raw word returned by the data cache.
- `mem_load_miss` in 1: the cache reports a load miss this cycle.
- `refill_complete` in 1: one-cycle pulse when the cache line fill is done.
- `stall_req` out 1: freeze IF, ID, EX and MEM.
- `wb_we` out 1: register-file write enable.
- `wb_rd` out RA_W: register-file write address.
- `wb_data` out XLEN: register-file write data.
- `misalign_err` out 1: one-cycle pulse on a misaligned load.
- `perf_stall_cycles` out 32: count of miss-stall cycles.

## Operation
- FSM states: RUN, MISS_WAIT, REPLAY, DRAIN.
- RUN:
  - Each cycle, register a result if `mem_valid` is 1 and `flush` is 0.
  - Data source: `mem_mem_to_reg` selects the aligned load data; otherwise `mem_alu_result`.
  - Write enable: `wb_we` = `mem_reg_write` AND `rd` ≠ 0 AND not misaligned.
  - Load miss: if `mem_load_miss` is 1 on a valid, unflushed load, write a bubble (`wb_we` = 0), latch `rd`/`funct3`/offset, assert `stall_req`, go to MISS_WAIT.
- MISS_WAIT:
  - `stall_req` = 1.
  - `flush` = 1: go to DRAIN.
  - `refill_complete` = 1: go to REPLAY.
- REPLAY:
  - `stall_req` = 1 for this one cycle; the cache now hits.
  - Sample `mem_load_data`, align it with the latched fields, commit to the `wb_*` outputs, go to RUN.
  - A `flush` asserted in REPLAY still commits: the replay is already architectural.
- DRAIN:
  - `stall_req` = 1; wait for `refill_complete`, then go to RUN with no commit.
  - If `refill_complete` and `flush` arrive in the same cycle in MISS_WAIT, go to RUN with no commit.
- Alignment, with `off` = `mem_alu_result[1:0]`:
  - LB/LBU: select byte `off`, then sign- or zero-extend.
  - LH/LHU: select half `off[1]`; `off[0]` = 1 is misaligned.
  - LW: `off` ≠ 0 is misaligned.
  - A misaligned load sets `wb_we` = 0 and pulses `misalign_err` with the registered result; a miss is not entered.
- Stores and non-writing instructions produce `wb_we` = 0.

## Timing
- Reset (`rst` = 0): `wb_we`, `wb_rd`, `wb_data`, `misalign_err`, `stall_req` and `perf_stall_cycles` all go to 0; FSM goes to RUN.
- Hit latency: MEM inputs at edge N appear on `wb_*` after edge N+1.
- Miss penalty: `stall_req` rises in the cycle after the miss is sampled. It stays high through MISS_WAIT and REPLAY and falls in the cycle after the REPLAY commit.
- `stall_req` is registered, not combinational from `mem_load_miss`.
- Reset asserted mid-miss: abandon the pending load immediately; no commit afterwards.

## Configuration
- `WB_PERF_CNT_EN` defined:
  - `perf_stall_cycles` increments in every cycle where `stall_req` = 1.
  - Saturates at 0xFFFF_FFFF; cleared only by reset.
- `WB_PERF_CNT_EN` undefined: the counter is not built and `perf_stall_cycles` is tied to 0.

## Structure
- Package `wb_pkg`: funct3 load encodings (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`) and the FSM state typedef `wb_state_t`.
- One sub-module, `load_align`: combinational; inputs funct3, offset and raw word; outputs aligned data and a misaligned flag. Instantiated once and shared by RUN and REPLAY.

## Test plan
- LB at address 0x1003, raw data 0x80FF_1234 -> `wb_data` 0xFFFF_FF80, `wb_we` 1, one cycle later.
- LHU at 0x1002, raw data 0xBEEF_0000 -> 0x0000_BEEF; LH at 0x1001 -> `misalign_err` pulse, `wb_we` 0.
- LW with `mem_load_miss`, then `refill_complete` 5 cycles later, then raw data 0xDEAD_BEEF:
  - `stall_req` high for 7 cycles; single commit of 0xDEAD_BEEF.
  - `perf_stall_cycles` = 7 with the macro defined, 0 without.
- Miss, then `flush` in MISS_WAIT, then `refill_complete` -> no write; `stall_req` drops the cycle after refill.
- ALU op writing x0 with result 0x1234 -> `wb_we` 0; ALU op writing x5 -> `wb_we` 1, `wb_data` 0x1234.
- Reset pulsed while in MISS_WAIT -> all outputs 0 asynchronously; no commit after reset releases.
